ps2_ascii_rx: RTL
=================

PS2_ASCII_RX -- requirements
Module: ps2_ascii_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: CLK cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 SHALL have port CLK, input, 1: sole system clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port PS2_CLK, input, 1: raw keyboard clock, asynchronous to CLK.
REQ-005 SHALL have port PS2_DATA, input, 1: raw keyboard data, asynchronous to CLK.
REQ-006 SHALL have port ascii, output, 8: last accepted key code, held until the next accepted key.
REQ-007 SHALL have port new_ascii, output, 1: one-CLK pulse marking a fresh value on ascii.
REQ-008 SHALL have port frame_err, output, 1: one-CLK pulse on a bad frame (start, stop, or parity) or a timeout.

Function
REQ-009 SHALL pass PS2_CLK and PS2_DATA through 2-flop synchronizers, then detect PS2_CLK falling edges as synchronized 1->0.
REQ-010 SHALL sample the synchronized data once per falling edge, in order: start(0), D0..D7 (LSB first), odd parity, stop(1).
REQ-011 SHALL use receive FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on start=0; start=1 stays IDLE with no error.
REQ-012 SHALL run a bit counter 0..7 in DATA, going DATA->PARITY after D7, PARITY->STOP, STOP->IDLE.
REQ-013 SHALL, on frame completion, validate stop=1 (and parity if enabled, REQ-022); on failure, pulse frame_err, discard the byte, and leave the prefix flags unchanged.
REQ-014 SHALL count CLK cycles between falling edges when not in IDLE; on reaching TIMEOUT_CYCLES, return to IDLE, pulse frame_err, and clear the prefix flags.
REQ-015 SHALL, on a valid byte 0xF0, set break_pending with no output.
REQ-016 SHALL, on a valid byte 0xE0, set ext_pending with no output.
REQ-017 SHALL, on any other valid byte, clear both flags, and emit only if both flags were clear beforehand and the byte is in the map.
REQ-018 SHALL map make codes 0x1D->0x57 'W', 0x1C->0x41 'A', 0x1B->0x53 'S', 0x23->0x44 'D', 0x5A->0x0D CR; unmapped codes produce no pulse and leave ascii unchanged.
REQ-019 SHALL, when emitting, update ascii and pulse new_ascii in the CLK cycle after the cycle in which the stop-bit falling edge is detected.
REQ-020 SHALL produce at most one new_ascii pulse per frame; held keys (typematic repeats) SHALL each produce a pulse.

Reset
REQ-021 SHALL, while RESET=1, force FSM=IDLE, bit counter=0, timeout counter=0, break_pending=0, ext_pending=0, ascii=8'h00, new_ascii=0, frame_err=0, and synchronizer flops=1; a frame in flight SHALL be discarded with no pulse after release.

Configuration
REQ-022 SHALL, with macro PS2_PARITY_CHECK_EN defined, reject frames where XOR(D0..D7, parity) != 1; without it, SHALL sample and ignore the parity bit, and stop-bit validation alone SHALL determine frame_err.

Structure
REQ-023 SHALL place the scan-code constants (0xF0, 0xE0, the five make codes), the ASCII constants (0x57, 0x41, 0x53, 0x44, 0x0D), and the FSM state encodings in shared package chess_pkg.
REQ-024 SHALL implement the combinational make-code-to-ASCII map as sub-module ps2_scan2ascii, outputs ascii_code[7:0] and hit.

Verification
REQ-025 SHALL verify: frame 0x1D, odd parity ok -> ascii=0x57, new_ascii high exactly 1 CLK, frame_err=0.
REQ-026 SHALL verify: sequence 0x1C, 0xF0, 0x1C -> exactly one pulse, ascii=0x41; the release produces no pulse.
REQ-027 SHALL verify: 0xE0, 0x1B -> no pulse; a following 0x1B -> pulse with ascii=0x53.
REQ-028 SHALL verify: with PS2_PARITY_CHECK_EN defined, 0x23 with wrong parity -> frame_err pulse, no new_ascii; without the macro -> ascii=0x44.
REQ-029 SHALL verify: PS2_CLK stops after 5 bits for more than TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next valid 0x5A -> ascii=0x0D.
REQ-030 SHALL verify: RESET asserted mid-frame at bit 4 -> ascii=0x00, no pulses; frame after release decodes normally.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared PS/2 receiver constants: scan codes, ASCII codes and receive FSM states.
package chess_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Prefix scan codes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Make codes for the mapped keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic [7:0] ASC_W  = 8'h57;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_D  = 8'h44;
  localparam logic [7:0] ASC_CR = 8'h0D;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational make-code to ASCII lookup; hit is low for unmapped codes.
module ps2_scan2ascii
  import chess_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic       hit
);

  always_comb begin
    ascii_code = 8'h00;
    hit        = 1'b1;
    case (scan_code)
      SC_W:     ascii_code = ASC_W;
      SC_A:     ascii_code = ASC_A;
      SC_S:     ascii_code = ASC_S;
      SC_D:     ascii_code = ASC_D;
      SC_ENTER: ascii_code = ASC_CR;
      default:  hit        = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_ascii_rx.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes scan codes and emits ASCII.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_ascii_rx
  import chess_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] ascii,
  output logic       new_ascii,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic            ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic            ps2_data_p0, ps2_data_p1;
  logic            clk_fall;
  logic            bit_in;

  rx_state_e       state, state_nx;
  logic [2:0]      bit_cnt, bit_cnt_nx;
  logic [TO_W-1:0] to_cnt, to_cnt_nx;
  logic            frame_done;
  logic            timeout;
  logic            frame_ok;

  logic [7:0]      shift_reg;
  logic [7:0]      map_ascii;
  logic            map_hit;
  logic            break_pending;
  logic            ext_pending;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous clock level for edge detect.
  // Idle-high reset keeps a release from looking like a falling edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= PS2_CLK;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= PS2_DATA;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign clk_fall = ps2_clk_p2 & ~ps2_clk_p1;
  assign bit_in   = ps2_data_p1;

  // Receive FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      to_cnt  <= to_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    to_cnt_nx  = to_cnt;
    frame_done = 1'b0;
    timeout    = 1'b0;

    // Watchdog runs only inside a frame and restarts on every falling edge.
    if (state == IDLE || clk_fall) begin
      to_cnt_nx = '0;
    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      timeout    = 1'b1;
      to_cnt_nx  = '0;
      state_nx   = IDLE;
      bit_cnt_nx = 3'd0;
    end else begin
      to_cnt_nx = to_cnt + TO_W'(1);
    end

    if (clk_fall) begin
      case (state)
        IDLE: begin
          if (!bit_in) begin
            state_nx   = DATA;
            bit_cnt_nx = 3'd0;
          end
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            state_nx   = PARITY;
            bit_cnt_nx = 3'd0;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
        PARITY: state_nx = STOP;
        STOP: begin
          state_nx   = IDLE;
          frame_done = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Data capture, LSB first into the top of the shift register
  always_ff @(posedge CLK) begin
    if (clk_fall && state == DATA) shift_reg <= {bit_in, shift_reg[7:1]};
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;

  always_ff @(posedge CLK) begin
    if (clk_fall && state == PARITY) parity_bit <= bit_in;
  end

  assign frame_ok = bit_in & odd_parity_ok(shift_reg, parity_bit);
`else
  assign frame_ok = bit_in;
`endif

  ps2_scan2ascii u_scan2ascii (
    .scan_code  (shift_reg),
    .ascii_code (map_ascii),
    .hit        (map_hit)
  );

  // Output stage: prefix tracking and registered one-cycle pulses
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      ascii         <= 8'h00;
      new_ascii     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      new_ascii <= 1'b0;
      frame_err <= 1'b0;
      if (timeout) begin
        frame_err     <= 1'b1;
        break_pending <= 1'b0;
        ext_pending   <= 1'b0;
      end else if (frame_done) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
        end else if (shift_reg == SC_BREAK) begin
          break_pending <= 1'b1;
        end else if (shift_reg == SC_EXT) begin
          ext_pending <= 1'b1;
        end else begin
          break_pending <= 1'b0;
          ext_pending   <= 1'b0;
          // Release codes and extended keys are swallowed along with their prefix.
          if (!break_pending && !ext_pending && map_hit) begin
            ascii     <= map_ascii;
            new_ascii <= 1'b1;
          end
        end
      end
    end
  end

endmodule
